// File: rtl/axil_target_sequencer_if.sv
// Master-facing request/response bus of the target sequencer.
interface axil_target_sequencer_if;
    logic [17:0] raddr;
    logic        rstart;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic [17:0] waddr;
    logic        wstart;
    logic        wready;
    logic        bready;
    logic [1:0]  bresp;
    logic        bvalid;

    modport master (
        output raddr, rstart, rready, waddr, wstart, bready,
        input  rdata, rresp, rvalid, wready, bresp, bvalid
    );

    modport slave (
        input  raddr, rstart, rready, waddr, wstart, bready,
        output rdata, rresp, rvalid, wready, bresp, bvalid
    );
endinterface

// File: rtl/axil_target_sequencer.sv
// Bridges single read/write requests onto five strobe/ack targets
// (fc, gt[1:0], wb[1:0]) with one transaction in flight, an ack timeout
// and AXI-style OKAY/SLVERR/DECERR responses.
module axil_target_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    axilClk,
    input  logic                    axilRst,
    axil_target_sequencer_if.slave  bus,

    output logic                    fc_wstr,
    output logic                    fc_rstr,
    input  logic                    fc_wack,
    input  logic                    fc_rack,
    input  logic [31:0]             fc_din,

    output logic [1:0]              gt_wstr,
    output logic [1:0]              gt_rstr,
    input  logic [1:0]              gt_wack,
    input  logic [1:0]              gt_rack,
    input  logic [63:0]             gt_din,

    output logic [1:0]              wb_wstr,
    output logic [1:0]              wb_rstr,
    input  logic [1:0]              wb_wack,
    input  logic [1:0]              wb_rack,
    input  logic [63:0]             wb_din,

    output logic [15:0]             timeout_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RSTB,
        S_RRESP,
        S_WSTB,
        S_WRESP
    } state_t;

    localparam int          NUM_TGT     = 5;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [15:0] TIMER_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t               state;
    state_t               state_nxt;

    logic                 rstart_q;
    logic                 read_pending;
    logic                 rstart_rise;
    logic                 read_go;
    logic                 write_go;

    // Target index is addr[11:8] of the transaction in flight.
    logic [3:0]           tgt_q;
    logic                 tgt_valid;
    logic [NUM_TGT-1:0]   tgt_onehot;
    logic [31:0]          din_sel;

    // Strobe vector, bit order: fc, gt[0], gt[1], wb[0], wb[1].
    logic [NUM_TGT-1:0]   stb_q;
    logic [NUM_TGT-1:0]   rack_vec;
    logic [NUM_TGT-1:0]   wack_vec;
    logic [NUM_TGT-1:0]   ack_vec;
    logic                 stb_on;
    logic                 ack_hit;
    logic [15:0]          timer_q;
    logic                 timer_expired;

    logic                 stb_launch;
    logic                 done_ok;
    logic                 done_tmo;
    logic                 done_decerr;

    logic [31:0]          rdata_q;
    logic [1:0]           rresp_q;
    logic [1:0]           bresp_q;
    logic [15:0]          tmo_cnt_q;

    // Address bits outside the decode field carry no meaning here.
    logic                 unused_addr_bits;
    assign unused_addr_bits = ^{bus.raddr[17:12], bus.raddr[7:0],
                                bus.waddr[17:12], bus.waddr[7:0]};

    // Request arbitration: a fresh rstart edge counts as a read start at once.
    assign rstart_rise = bus.rstart & ~rstart_q;
    assign read_go     = read_pending | rstart_rise;
    assign write_go    = bus.wstart & ~read_go;

    assign tgt_valid  = (tgt_q < 4'd5);
    assign tgt_onehot = tgt_valid ? (NUM_TGT'(1) << tgt_q) : '0;

    assign rack_vec = {wb_rack, gt_rack, fc_rack};
    assign wack_vec = {wb_wack, gt_wack, fc_wack};
    assign ack_vec  = (state == S_RSTB) ? rack_vec : wack_vec;
    assign stb_on   = |stb_q;
    // Masking with the strobe keeps acks from unselected targets out.
    assign ack_hit       = |(stb_q & ack_vec);
    assign timer_expired = (timer_q == TIMER_LAST);

    // Read data mux for the selected target.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path infers a latch.
        din_sel = 32'h0;
        case (tgt_q)
            4'd0:    din_sel = fc_din;
            4'd1:    din_sel = gt_din[31:0];
            4'd2:    din_sel = gt_din[63:32];
            4'd3:    din_sel = wb_din[31:0];
            4'd4:    din_sel = wb_din[63:32];
            default: din_sel = 32'h0;
        endcase
    end

    // State register.
    always_ff @(posedge axilClk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (axilRst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-cycle completion decisions.
    always_comb begin
        state_nxt   = state;
        stb_launch  = 1'b0;
        done_ok     = 1'b0;
        done_tmo    = 1'b0;
        done_decerr = 1'b0;
        case (state)
            S_IDLE: begin
                if (read_go) begin
                    state_nxt = S_RSTB;
                end else if (write_go) begin
                    state_nxt = S_WSTB;
                end
            end
            S_RSTB, S_WSTB: begin
                if (!stb_on) begin
                    if (tgt_valid) begin
                        stb_launch = 1'b1;
                    end else begin
                        done_decerr = 1'b1;
                    end
                end else if (ack_hit) begin
                    done_ok = 1'b1;
                end else if (timer_expired) begin
                    done_tmo = 1'b1;
                end
                if (done_ok || done_tmo || done_decerr) begin
                    state_nxt = (state == S_RSTB) ? S_RRESP : S_WRESP;
                end
            end
            S_RRESP: begin
                if (bus.rready) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WRESP: begin
                if (bus.bready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Edge detector history; follows rstart through reset.
    always_ff @(posedge axilClk) begin
        // NOTE: left out of reset on purpose so a level held across reset is not seen as a new edge.
        rstart_q <= bus.rstart;
    end

    // Request latch, strobe/timer control, response capture and timeout count.
    always_ff @(posedge axilClk) begin
        if (axilRst) begin
            read_pending <= 1'b0;
            tgt_q        <= 4'd0;
            stb_q        <= '0;
            timer_q      <= 16'd0;
            rdata_q      <= 32'h0;
            rresp_q      <= RESP_OKAY;
            bresp_q      <= RESP_OKAY;
            tmo_cnt_q    <= 16'd0;
        end else begin
            if (state == S_IDLE) begin
                read_pending <= 1'b0;
                if (read_go) begin
                    tgt_q <= bus.raddr[11:8];
                end else if (write_go) begin
                    tgt_q <= bus.waddr[11:8];
                end
            end else if (rstart_rise && (state inside {S_WSTB, S_WRESP})) begin
                read_pending <= 1'b1;
            end

            if (stb_launch) begin
                stb_q   <= tgt_onehot;
                timer_q <= 16'd0;
            end else if (stb_on) begin
                if (done_ok || done_tmo) begin
                    stb_q <= '0;
                end else begin
                    timer_q <= timer_q + 16'd1;
                end
            end

            if (state == S_RSTB) begin
                if (done_ok) begin
                    rdata_q <= din_sel;
                    rresp_q <= RESP_OKAY;
                end else if (done_tmo) begin
                    rdata_q <= 32'hDEAD_DEAD;
                    rresp_q <= RESP_SLVERR;
                end else if (done_decerr) begin
                    rdata_q <= 32'h0;
                    rresp_q <= RESP_DECERR;
                end
            end

            if (state == S_WSTB) begin
                if (done_ok) begin
                    bresp_q <= RESP_OKAY;
                end else if (done_tmo) begin
                    bresp_q <= RESP_SLVERR;
                end else if (done_decerr) begin
                    bresp_q <= RESP_DECERR;
                end
            end

            if (done_tmo && (tmo_cnt_q != 16'hFFFF)) begin
                tmo_cnt_q <= tmo_cnt_q + 16'd1;
            end
        end
    end

    // Output mapping.
    assign bus.rdata  = rdata_q;
    assign bus.rresp  = rresp_q;
    assign bus.rvalid = (state == S_RRESP);
    assign bus.bresp  = bresp_q;
    assign bus.bvalid = (state == S_WRESP);
    assign bus.wready = (state == S_IDLE) & write_go & ~axilRst;

    assign fc_rstr = (state == S_RSTB) & stb_q[0];
    assign gt_rstr = (state == S_RSTB) ? stb_q[2:1] : 2'b00;
    assign wb_rstr = (state == S_RSTB) ? stb_q[4:3] : 2'b00;
    assign fc_wstr = (state == S_WSTB) & stb_q[0];
    assign gt_wstr = (state == S_WSTB) ? stb_q[2:1] : 2'b00;
    assign wb_wstr = (state == S_WSTB) ? stb_q[4:3] : 2'b00;

    assign timeout_count = tmo_cnt_q;

endmodule

// File: tb/tb_axil_target_sequencer.sv
// Directed bench for axil_target_sequencer (TIMEOUT_CYCLES = 8).
module tb_axil_target_sequencer;

    logic        axilClk;
    logic        axilRst;

    logic        fc_wstr, fc_rstr, fc_wack, fc_rack;
    logic [31:0] fc_din;
    logic [1:0]  gt_wstr, gt_rstr, gt_wack, gt_rack;
    logic [63:0] gt_din;
    logic [1:0]  wb_wstr, wb_rstr, wb_wack, wb_rack;
    logic [63:0] wb_din;
    logic [15:0] timeout_count;

    axil_target_sequencer_if bus ();

    axil_target_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .axilClk       (axilClk),
        .axilRst       (axilRst),
        .bus           (bus),
        .fc_wstr       (fc_wstr),
        .fc_rstr       (fc_rstr),
        .fc_wack       (fc_wack),
        .fc_rack       (fc_rack),
        .fc_din        (fc_din),
        .gt_wstr       (gt_wstr),
        .gt_rstr       (gt_rstr),
        .gt_wack       (gt_wack),
        .gt_rack       (gt_rack),
        .gt_din        (gt_din),
        .wb_wstr       (wb_wstr),
        .wb_rstr       (wb_rstr),
        .wb_wack       (wb_wack),
        .wb_rack       (wb_rack),
        .wb_din        (wb_din),
        .timeout_count (timeout_count)
    );

    initial axilClk = 1'b0;
    always #5 axilClk = ~axilClk;

    // Target model: bit order fc, gt[0], gt[1], wb[0], wb[1].
    // auto = ack in the same cycle the strobe is seen; man = forced ack.
    logic [4:0] rack_auto, wack_auto, rack_man, wack_man;
    logic [4:0] rstr_v, wstr_v, rack_v, wack_v;
    assign rstr_v  = {wb_rstr, gt_rstr, fc_rstr};
    assign wstr_v  = {wb_wstr, gt_wstr, fc_wstr};
    assign rack_v  = (rstr_v & rack_auto) | rack_man;
    assign wack_v  = (wstr_v & wack_auto) | wack_man;
    assign fc_rack = rack_v[0];
    assign gt_rack = rack_v[2:1];
    assign wb_rack = rack_v[4:3];
    assign fc_wack = wack_v[0];
    assign gt_wack = wack_v[2:1];
    assign wb_wack = wack_v[4:3];

    // Strobe monitor: [4:0] read strobes, [9:5] write strobes.
    logic [9:0] stb_all;
    assign stb_all = {wstr_v, rstr_v};
    int stb_hi [10];
    int onehot_viol;
    int rvalid_hi;
    int wready_hi;

    initial begin
        onehot_viol = 0;
        rvalid_hi   = 0;
        wready_hi   = 0;
        for (int i = 0; i < 10; i++) stb_hi[i] = 0;
    end

    always @(negedge axilClk) begin
        if (!$onehot0(stb_all)) onehot_viol++;
        for (int i = 0; i < 10; i++) if (stb_all[i]) stb_hi[i]++;
        if (bus.rvalid) rvalid_hi++;
        if (bus.wready) wready_hi++;
    end

    function automatic int stb_total();
        int t = 0;
        for (int i = 0; i < 10; i++) t += stb_hi[i];
        return t;
    endfunction

    int checks;
    int failures;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge axilClk);
        #1;
    endtask

    // Counts cycles from the request cycle until the response valid shows up.
    task automatic wait_resp(input bit rd, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            cyc();
            n++;
            bus.rstart = 1'b0;
            if (!rd) bus.wstart = 1'b0;
            if (rd ? bus.rvalid : bus.bvalid) break;
        end
        if (!(rd ? bus.rvalid : bus.bvalid)) n = -1;
    endtask

    task automatic end_read(input string tag);
        bus.rready = 1'b1;
        cyc();
        check({tag, "_rvalid_clear"}, bus.rvalid, 1'b0);
        bus.rready = 1'b0;
    endtask

    task automatic end_write(input string tag);
        bus.bready = 1'b1;
        cyc();
        check({tag, "_bvalid_clear"}, bus.bvalid, 1'b0);
        bus.bready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    int n;
    int base;
    int base2;

    initial begin
        checks     = 0;
        failures   = 0;
        axilRst    = 1'b1;
        bus.raddr  = '0;
        bus.rstart = 1'b0;
        bus.rready = 1'b0;
        bus.waddr  = '0;
        bus.wstart = 1'b0;
        bus.bready = 1'b0;
        fc_din     = '0;
        gt_din     = '0;
        wb_din     = '0;
        rack_auto  = '0;
        wack_auto  = '0;
        rack_man   = '0;
        wack_man   = '0;

        // Reset state
        repeat (3) cyc();
        check("rst_flags", {bus.rvalid, bus.bvalid, bus.wready, bus.rresp, bus.bresp}, 7'd0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_tmo_count", timeout_count, 16'h0);
        check("rst_strobes", stb_all, 10'h0);
        axilRst = 1'b0;
        cyc();

        // Read fc with immediate ack: 3-cycle latency, rvalid held until rready
        bus.raddr  = 18'h00000;
        fc_din     = 32'hA5A5_0001;
        rack_auto  = 5'b00001;
        bus.rstart = 1'b1;
        wait_resp(1'b1, 40, n);
        check("rd_fc_latency", n, 3);
        check("rd_fc_rdata", bus.rdata, 32'hA5A5_0001);
        check("rd_fc_rresp", bus.rresp, 2'b00);
        cyc();
        cyc();
        check("rd_fc_hold_valid", bus.rvalid, 1'b1);
        check("rd_fc_hold_data", bus.rdata, 32'hA5A5_0001);
        end_read("rd_fc");
        rack_auto = '0;

        // Write fc with immediate ack: wready pulse, 3-cycle latency to bvalid
        bus.waddr  = 18'h000AC;
        wack_auto  = 5'b00001;
        bus.wstart = 1'b1;
        #1;
        check("wr_fc_wready", bus.wready, 1'b1);
        wait_resp(1'b0, 40, n);
        check("wr_fc_latency", n, 3);
        check("wr_fc_bresp", bus.bresp, 2'b00);
        end_write("wr_fc");
        wack_auto = '0;

        // gt[0] read, ack 2 cycles after strobe rises; foreign acks ignored
        bus.raddr  = 18'h00100;
        gt_din     = {32'hCAFE_F00D, 32'h1234_5678};
        bus.rstart = 1'b1;
        cyc();
        bus.rstart = 1'b0;
        cyc();
        check("gt0_stb_rise", gt_rstr, 2'b01);
        cyc();
        rack_man = 5'b10101;
        wack_man = 5'b00010;
        cyc();
        check("gt0_foreign_ack_ignored", bus.rvalid, 1'b0);
        check("gt0_stb_held", gt_rstr, 2'b01);
        rack_man = 5'b00010;
        wack_man = '0;
        cyc();
        rack_man = '0;
        check("gt0_rvalid", bus.rvalid, 1'b1);
        check("gt0_stb_drop", gt_rstr, 2'b00);
        check("gt0_rdata", bus.rdata, 32'h1234_5678);
        check("gt0_rresp", bus.rresp, 2'b00);
        cyc();
        cyc();
        check("gt0_hold", {bus.rvalid, bus.rdata}, {1'b1, 32'h1234_5678});
        end_read("gt0");

        // wb[1] write never acked: 8 strobe cycles, SLVERR, count 1
        base       = stb_hi[9];
        bus.waddr  = 18'h00403;
        bus.wstart = 1'b1;
        wait_resp(1'b0, 40, n);
        check("wb1_tmo_latency", n, 10);
        check("wb1_tmo_stb_cycles", stb_hi[9] - base, 8);
        check("wb1_tmo_bresp", bus.bresp, 2'b10);
        check("wb1_tmo_count", timeout_count, 16'd1);
        end_write("wb1_tmo");

        // Undecoded read: no strobe, DECERR, rdata 0
        base       = stb_total();
        bus.raddr  = 18'h00700;
        bus.rstart = 1'b1;
        wait_resp(1'b1, 40, n);
        check("decerr_latency", n, 2);
        check("decerr_rresp", bus.rresp, 2'b11);
        check("decerr_rdata", bus.rdata, 32'h0);
        check("decerr_no_strobe", stb_total() - base, 0);
        end_read("decerr");

        // addr[17:12] ignored: 0x3F200 selects gt[1]
        rack_auto  = 5'b00100;
        bus.raddr  = 18'h3F200;
        bus.rstart = 1'b1;
        wait_resp(1'b1, 40, n);
        check("hibits_latency", n, 3);
        check("hibits_rdata", bus.rdata, 32'hCAFE_F00D);
        check("hibits_rresp", bus.rresp, 2'b00);
        end_read("hibits");
        rack_auto = '0;

        // Read edge and write valid in the same cycle to fc: read first
        base       = wready_hi;
        fc_din     = 32'h0BAD_C0DE;
        rack_auto  = 5'b00001;
        wack_auto  = 5'b00001;
        bus.raddr  = 18'h00000;
        bus.waddr  = 18'h00010;
        bus.rstart = 1'b1;
        bus.wstart = 1'b1;
        #1;
        check("rw_read_wins", bus.wready, 1'b0);
        wait_resp(1'b1, 40, n);
        check("rw_read_latency", n, 3);
        check("rw_read_rdata", bus.rdata, 32'h0BAD_C0DE);
        bus.rready = 1'b1;
        cyc();
        bus.rready = 1'b0;
        #1;
        check("rw_rvalid_clear", bus.rvalid, 1'b0);
        check("rw_wready_after_read", bus.wready, 1'b1);
        wait_resp(1'b0, 40, n);
        check("rw_write_latency", n, 3);
        check("rw_write_bresp", bus.bresp, 2'b00);
        check("rw_single_wready", wready_hi - base, 1);
        end_write("rw");
        rack_auto = '0;
        wack_auto = '0;

        // Reset while fc_rstr high abandons the read; late ack ignored
        bus.raddr  = 18'h00000;
        bus.rstart = 1'b1;
        cyc();
        bus.rstart = 1'b0;
        cyc();
        check("rst_mid_stb_on", fc_rstr, 1'b1);
        axilRst = 1'b1;
        cyc();
        check("rst_mid_stb_off", fc_rstr, 1'b0);
        check("rst_mid_rvalid", bus.rvalid, 1'b0);
        check("rst_mid_tmo_count", timeout_count, 16'd0);
        axilRst  = 1'b0;
        rack_man = 5'b00001;
        cyc();
        cyc();
        check("rst_mid_late_ack", {bus.rvalid, fc_rstr}, 2'b00);
        rack_man = '0;
        cyc();
        fc_din     = 32'h600D_F00D;
        rack_auto  = 5'b00001;
        bus.rstart = 1'b1;
        wait_resp(1'b1, 40, n);
        check("rst_mid_next_latency", n, 3);
        check("rst_mid_next_rresp", bus.rresp, 2'b00);
        check("rst_mid_next_rdata", bus.rdata, 32'h600D_F00D);
        end_read("rst_mid_next");
        rack_auto = '0;

        // Ack in the last timeout cycle wins: OKAY and no count
        bus.waddr  = 18'h00300;
        bus.wstart = 1'b1;
        cyc();
        bus.wstart = 1'b0;
        for (int k = 2; k <= 9; k++) cyc();
        check("collide_stb_last", wb_wstr, 2'b01);
        wack_man = 5'b01000;
        cyc();
        wack_man = '0;
        check("collide_bvalid", bus.bvalid, 1'b1);
        check("collide_bresp", bus.bresp, 2'b00);
        check("collide_tmo_count", timeout_count, 16'd0);
        check("collide_stb_off", wb_wstr, 2'b00);
        end_write("collide");

        // gt[1] read timeout: SLVERR with DEADDEAD
        bus.raddr  = 18'h00200;
        bus.rstart = 1'b1;
        wait_resp(1'b1, 40, n);
        check("rd_tmo_latency", n, 10);
        check("rd_tmo_rresp", bus.rresp, 2'b10);
        check("rd_tmo_rdata", bus.rdata, 32'hDEAD_DEAD);
        check("rd_tmo_count", timeout_count, 16'd1);
        end_read("rd_tmo");

        // rstart held for 3 cycles issues exactly one read
        base       = rvalid_hi;
        base2      = stb_hi[0];
        rack_auto  = 5'b00001;
        bus.rready = 1'b1;
        bus.raddr  = 18'h00000;
        bus.rstart = 1'b1;
        cyc();
        cyc();
        cyc();
        bus.rstart = 1'b0;
        repeat (8) cyc();
        check("held_one_rvalid", rvalid_hi - base, 1);
        check("held_one_strobe", stb_hi[0] - base2, 1);
        bus.rready = 1'b0;
        rack_auto  = '0;

        check("onehot_strobes", onehot_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
